// File: rtl/decode_stage_pipe_if.sv
// Bundle of the IF->ID handshake, register/CSR read ports, EX hazard feedback and the decoded ID->EX bundle.
// The decode stage takes the slave view; the surrounding pipeline (or a bench) takes the master view.
interface decode_stage_pipe_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CSR_AW = 12,
    parameter int CNT_W  = 16
);
    logic              flush_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [31:0]       inst_i;
    logic [XLEN-1:0]   inst_addr_i;
    logic [REG_AW-1:0] reg1_raddr_o;
    logic [REG_AW-1:0] reg2_raddr_o;
    logic [XLEN-1:0]   reg1_rdata_i;
    logic [XLEN-1:0]   reg2_rdata_i;
    logic [CSR_AW-1:0] csr_raddr_o;
    logic [XLEN-1:0]   csr_rdata_i;
    logic              ex_load_pending_i;
    logic [REG_AW-1:0] ex_load_rd_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [XLEN-1:0]   op1_o;
    logic [XLEN-1:0]   op2_o;
    logic [XLEN-1:0]   offset_o;
    logic [31:0]       inst_o;
    logic [XLEN-1:0]   inst_addr_o;
    logic              reg_wen_o;
    logic [REG_AW-1:0] reg_waddr_o;
    logic              csr_wen_o;
    logic [CSR_AW-1:0] csr_waddr_o;
    logic [XLEN-1:0]   csr_rdata_o;
    logic              illegal_o;
    logic [CNT_W-1:0]  stall_cnt_o;

    modport slave (
        input  flush_i, in_valid_i, inst_i, inst_addr_i, reg1_rdata_i, reg2_rdata_i, csr_rdata_i,
               ex_load_pending_i, ex_load_rd_i, out_ready_i,
        output in_ready_o, reg1_raddr_o, reg2_raddr_o, csr_raddr_o, out_valid_o, op1_o, op2_o,
               offset_o, inst_o, inst_addr_o, reg_wen_o, reg_waddr_o, csr_wen_o, csr_waddr_o,
               csr_rdata_o, illegal_o, stall_cnt_o
    );

    modport master (
        output flush_i, in_valid_i, inst_i, inst_addr_i, reg1_rdata_i, reg2_rdata_i, csr_rdata_i,
               ex_load_pending_i, ex_load_rd_i, out_ready_i,
        input  in_ready_o, reg1_raddr_o, reg2_raddr_o, csr_raddr_o, out_valid_o, op1_o, op2_o,
               offset_o, inst_o, inst_addr_o, reg_wen_o, reg_waddr_o, csr_wen_o, csr_waddr_o,
               csr_rdata_o, illegal_o, stall_cnt_o
    );
endinterface

// File: rtl/decode_stage_pipe.sv
// RV32I/Zicsr decode stage: one instruction per cycle, registered decoded bundle towards EX,
// load-use bubble insertion, flush, illegal flagging and a saturating load-use stall counter.
module decode_stage_pipe #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CSR_AW = 12,
    parameter bit EN_CSR = 1'b1,
    parameter int CNT_W  = 16
) (
    input logic               clk_i,
    input logic               rst_i,
    decode_stage_pipe_if.slave bus
);
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    typedef enum logic {EMPTY, FULL} state_t;

    logic [31:0]     inst;
    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [4:0]      rs1_f, rs2_f, rd_f;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u, uimm;

    assign inst  = bus.inst_i;
    assign opc   = inst[6:0];
    assign f3    = inst[14:12];
    assign rs1_f = inst[19:15];
    assign rs2_f = inst[24:20];
    assign rd_f  = inst[11:7];
    assign imm_i = {{(XLEN-12){inst[31]}}, inst[31:20]};
    assign imm_s = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{(XLEN-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_j = {{(XLEN-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    assign imm_u = XLEN'($signed({inst[31:12], 12'b0}));
    assign uimm  = {{(XLEN-5){1'b0}}, rs1_f};

    // Instruction-class decode depends only on the instruction word, so the read addresses
    // never loop back through the register-file data.
    logic            dec_ill, use_rs1, use_rs2, is_csr, wr_rd, dec_csr_wen;
    logic [XLEN-1:0] dec_off;

    always_comb begin
        dec_ill     = 1'b0;
        use_rs1     = 1'b0;
        use_rs2     = 1'b0;
        is_csr      = 1'b0;
        wr_rd       = 1'b0;
        dec_csr_wen = 1'b0;
        dec_off     = '0;
        case (opc)
            OPC_OP: begin use_rs1 = 1'b1; use_rs2 = 1'b1; wr_rd = 1'b1; end
            OPC_OP_IMM: begin use_rs1 = 1'b1; wr_rd = 1'b1; end
            OPC_LOAD:
                if (f3 == 3'd3 || f3 >= 3'd6) dec_ill = 1'b1;
                else begin use_rs1 = 1'b1; wr_rd = 1'b1; end
            OPC_STORE:
                if (f3 > 3'd2) dec_ill = 1'b1;
                else begin use_rs1 = 1'b1; use_rs2 = 1'b1; dec_off = imm_s; end
            OPC_BRANCH:
                if (f3 == 3'd2 || f3 == 3'd3) dec_ill = 1'b1;
                else begin use_rs1 = 1'b1; use_rs2 = 1'b1; dec_off = imm_b; end
            OPC_JAL: begin wr_rd = 1'b1; dec_off = imm_j; end
            OPC_JALR:
                if (f3 != 3'd0) dec_ill = 1'b1;
                else begin use_rs1 = 1'b1; wr_rd = 1'b1; dec_off = imm_i; end
            OPC_LUI, OPC_AUIPC: wr_rd = 1'b1;
            OPC_SYSTEM:
                if (!EN_CSR || f3[1:0] == 2'd0) dec_ill = 1'b1;
                else begin
                    is_csr  = 1'b1;
                    wr_rd   = 1'b1;
                    use_rs1 = ~f3[2];
                    // set/clear with a zero mask only reads the CSR
                    dec_csr_wen = ~(f3[1] && rs1_f == 5'd0);
                end
            OPC_FENCE:
                if (f3 != 3'd0) dec_ill = 1'b1;
            default: dec_ill = 1'b1;
        endcase
    end

    logic [XLEN-1:0] dec_op1, dec_op2;

    always_comb begin
        dec_op1 = '0;
        dec_op2 = '0;
        if (!dec_ill) begin
            case (opc)
                OPC_OP, OPC_STORE, OPC_BRANCH: begin
                    dec_op1 = bus.reg1_rdata_i;
                    dec_op2 = bus.reg2_rdata_i;
                end
                OPC_OP_IMM, OPC_LOAD: begin
                    dec_op1 = bus.reg1_rdata_i;
                    dec_op2 = imm_i;
                end
                OPC_JAL:    dec_op1 = bus.inst_addr_i;
                OPC_JALR: begin
                    dec_op1 = bus.reg1_rdata_i;
                    dec_op2 = bus.inst_addr_i;
                end
                OPC_LUI:    dec_op1 = imm_u;
                OPC_AUIPC: begin
                    dec_op1 = imm_u;
                    dec_op2 = bus.inst_addr_i;
                end
                OPC_SYSTEM: dec_op1 = f3[2] ? uimm : bus.reg1_rdata_i;
                OPC_FENCE: begin
                    dec_op1 = bus.inst_addr_i;
                    dec_op2 = XLEN'(4);
                end
                default: ;
            endcase
        end
    end

    logic [REG_AW-1:0] rs1_addr, rs2_addr;
    logic [CSR_AW-1:0] csr_addr;
    logic              hazard, transfer;
    state_t            state_reg;

    assign rs1_addr = use_rs1 ? REG_AW'(rs1_f) : '0;
    assign rs2_addr = use_rs2 ? REG_AW'(rs2_f) : '0;
    assign csr_addr = is_csr ? CSR_AW'(inst[31:20]) : '0;

    // Unused source addresses are zero, so they can never match a nonzero load destination.
    assign hazard = bus.ex_load_pending_i && (bus.ex_load_rd_i != '0) &&
                    (bus.ex_load_rd_i == rs1_addr || bus.ex_load_rd_i == rs2_addr);

    assign bus.in_ready_o   = ~hazard & ~bus.flush_i & ((state_reg == EMPTY) | bus.out_ready_i);
    assign transfer         = bus.in_valid_i & bus.in_ready_o;
    assign bus.reg1_raddr_o = rs1_addr;
    assign bus.reg2_raddr_o = rs2_addr;
    assign bus.csr_raddr_o  = csr_addr;
    assign bus.out_valid_o  = (state_reg == FULL);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg       <= EMPTY;
            bus.op1_o       <= '0;
            bus.op2_o       <= '0;
            bus.offset_o    <= '0;
            bus.inst_o      <= '0;
            bus.inst_addr_o <= '0;
            bus.reg_wen_o   <= 1'b0;
            bus.reg_waddr_o <= '0;
            bus.csr_wen_o   <= 1'b0;
            bus.csr_waddr_o <= '0;
            bus.csr_rdata_o <= '0;
            bus.illegal_o   <= 1'b0;
            bus.stall_cnt_o <= '0;
        end else begin
            if (bus.flush_i) begin
                state_reg <= EMPTY;
            end else if (transfer) begin
                state_reg       <= FULL;
                bus.op1_o       <= dec_op1;
                bus.op2_o       <= dec_op2;
                bus.offset_o    <= dec_off;
                bus.inst_o      <= inst;
                bus.inst_addr_o <= bus.inst_addr_i;
                bus.reg_wen_o   <= wr_rd && (rd_f != 5'd0);
                bus.reg_waddr_o <= REG_AW'(rd_f);
                bus.csr_wen_o   <= dec_csr_wen;
                bus.csr_waddr_o <= csr_addr;
                bus.csr_rdata_o <= is_csr ? bus.csr_rdata_i : '0;
                bus.illegal_o   <= dec_ill;
            end else if (bus.out_ready_i) begin
                state_reg <= EMPTY;
            end
            if (bus.in_valid_i && hazard && !bus.flush_i && bus.stall_cnt_o != {CNT_W{1'b1}})
                bus.stall_cnt_o <= bus.stall_cnt_o + 1'b1;
        end
    end
endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed scenarios followed by randomized traffic, checked against a behavioural decode model
// and a valid/stall-count model of the stage.
module tb_decode_stage_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    decode_stage_pipe_if #(.XLEN(32), .REG_AW(5), .CSR_AW(12), .CNT_W(16)) bus ();

    decode_stage_pipe #(.XLEN(32), .REG_AW(5), .CSR_AW(12), .EN_CSR(1'b1), .CNT_W(16)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    logic [31:0] regs [32];
    logic [31:0] csr_data;
    assign bus.reg1_rdata_i = regs[bus.reg1_raddr_o];
    assign bus.reg2_rdata_i = regs[bus.reg2_raddr_o];
    assign bus.csr_rdata_i  = csr_data;

    typedef struct packed {
        logic [31:0] op1, op2, offset;
        logic        reg_wen;
        logic [4:0]  reg_waddr;
        logic        csr_wen;
        logic [11:0] csr_waddr;
        logic [31:0] csr_rdata;
        logic        illegal;
        logic [4:0]  ra1, ra2;
        logic [11:0] craddr;
        logic [31:0] inst, addr;
    } exp_t;

    int    n_vec = 0;
    int    n_err = 0;
    logic  m_valid;
    int    m_cnt;
    exp_t  m_b;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sext(input logic [31:0] v, input int w);
        return 32'($signed(v << (32 - w)) >>> (32 - w));
    endfunction

    function automatic exp_t ref_decode(input logic [31:0] i, input logic [31:0] pc);
        exp_t e;
        int   f3;
        logic u1, u2, wr, csr;
        e = '0; u1 = 0; u2 = 0; wr = 0; csr = 0;
        f3 = int'(i[14:12]);
        case (i[6:0])
            7'h33: begin u1 = 1; u2 = 1; wr = 1; e.op1 = regs[i[19:15]]; e.op2 = regs[i[24:20]]; end
            7'h13: begin u1 = 1; wr = 1; e.op1 = regs[i[19:15]]; e.op2 = sext(32'(i[31:20]), 12); end
            7'h03: if (f3 inside {0, 1, 2, 4, 5}) begin
                       u1 = 1; wr = 1; e.op1 = regs[i[19:15]]; e.op2 = sext(32'(i[31:20]), 12);
                   end else e.illegal = 1;
            7'h23: if (f3 <= 2) begin
                       u1 = 1; u2 = 1; e.op1 = regs[i[19:15]]; e.op2 = regs[i[24:20]];
                       e.offset = sext(32'({i[31:25], i[11:7]}), 12);
                   end else e.illegal = 1;
            7'h63: if (f3 inside {0, 1, 4, 5, 6, 7}) begin
                       u1 = 1; u2 = 1; e.op1 = regs[i[19:15]]; e.op2 = regs[i[24:20]];
                       e.offset = sext(32'({i[31], i[7], i[30:25], i[11:8], 1'b0}), 13);
                   end else e.illegal = 1;
            7'h6F: begin wr = 1; e.op1 = pc; e.offset = sext(32'({i[31], i[19:12], i[20], i[30:21], 1'b0}), 21); end
            7'h67: if (f3 == 0) begin
                       u1 = 1; wr = 1; e.op1 = regs[i[19:15]]; e.op2 = pc; e.offset = sext(32'(i[31:20]), 12);
                   end else e.illegal = 1;
            7'h37: begin wr = 1; e.op1 = {i[31:12], 12'h000}; end
            7'h17: begin wr = 1; e.op1 = {i[31:12], 12'h000}; e.op2 = pc; end
            7'h73: if (f3 inside {1, 2, 3, 5, 6, 7}) begin
                       csr = 1; wr = 1; u1 = (f3 < 4);
                       e.op1 = (f3 < 4) ? regs[i[19:15]] : 32'(i[19:15]);
                       e.csr_wen = !((f3 % 4) >= 2 && i[19:15] == 0);
                   end else e.illegal = 1;
            7'h0F: if (f3 == 0) begin e.op1 = pc; e.op2 = 4; end else e.illegal = 1;
            default: e.illegal = 1;
        endcase
        e.reg_wen   = wr && (i[11:7] != 0);
        e.reg_waddr = i[11:7];
        e.ra1       = u1 ? i[19:15] : 5'd0;
        e.ra2       = u2 ? i[24:20] : 5'd0;
        e.craddr    = csr ? i[31:20] : 12'h000;
        e.csr_waddr = e.craddr;
        e.csr_rdata = csr ? csr_data : 32'h0;
        e.inst      = i;
        e.addr      = pc;
        return e;
    endfunction

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic ordy, input logic fl, input logic pend, input logic [4:0] lrd);
        bus.in_valid_i        = v;
        bus.inst_i            = ins;
        bus.inst_addr_i       = pc;
        bus.out_ready_i       = ordy;
        bus.flush_i           = fl;
        bus.ex_load_pending_i = pend;
        bus.ex_load_rd_i      = lrd;
    endtask

    // Check one cycle against the model, clock it, then advance the model with the applied inputs.
    task automatic cycle();
        exp_t d;
        logic hz, rdy;
        #1;
        d   = ref_decode(bus.inst_i, bus.inst_addr_i);
        hz  = bus.ex_load_pending_i && bus.ex_load_rd_i != 0 &&
              (bus.ex_load_rd_i == d.ra1 || bus.ex_load_rd_i == d.ra2);
        rdy = !hz && !bus.flush_i && (!m_valid || bus.out_ready_i);
        chk("in_ready", bus.in_ready_o, rdy);
        chk("reg1_raddr", bus.reg1_raddr_o, d.ra1);
        chk("reg2_raddr", bus.reg2_raddr_o, d.ra2);
        chk("csr_raddr", bus.csr_raddr_o, d.craddr);
        chk("out_valid", bus.out_valid_o, m_valid);
        chk("stall_cnt", bus.stall_cnt_o, m_cnt);
        if (m_valid) begin
            chk("op1", bus.op1_o, m_b.op1);
            chk("op2", bus.op2_o, m_b.op2);
            chk("offset", bus.offset_o, m_b.offset);
            chk("inst", bus.inst_o, m_b.inst);
            chk("inst_addr", bus.inst_addr_o, m_b.addr);
            chk("reg_wen", bus.reg_wen_o, m_b.reg_wen);
            chk("reg_waddr", bus.reg_waddr_o, m_b.reg_waddr);
            chk("csr_wen", bus.csr_wen_o, m_b.csr_wen);
            chk("csr_waddr", bus.csr_waddr_o, m_b.csr_waddr);
            chk("csr_rdata", bus.csr_rdata_o, m_b.csr_rdata);
            chk("illegal", bus.illegal_o, m_b.illegal);
        end
        @(posedge clk);
        if (bus.flush_i) m_valid = 1'b0;
        else if (bus.in_valid_i && rdy) begin m_valid = 1'b1; m_b = d; end
        else if (bus.out_ready_i) m_valid = 1'b0;
        if (bus.in_valid_i && hz && !bus.flush_i && m_cnt < 65535) m_cnt++;
        #1;
        $display("cycle t=%0t in_v=%0b inst=%h in_rdy=%0b out_v=%0b stall=%0d",
                 $time, bus.in_valid_i, bus.inst_i, rdy, bus.out_valid_o, bus.stall_cnt_o);
    endtask

    task automatic chk_zero_bundle(input string tag);
        chk({tag, "_valid"}, bus.out_valid_o, 1'b0);
        chk({tag, "_stall"}, bus.stall_cnt_o, 16'd0);
        chk({tag, "_op1"}, bus.op1_o, 32'h0);
        chk({tag, "_op2"}, bus.op2_o, 32'h0);
        chk({tag, "_offset"}, bus.offset_o, 32'h0);
        chk({tag, "_inst"}, bus.inst_o, 32'h0);
        chk({tag, "_addr"}, bus.inst_addr_o, 32'h0);
        chk({tag, "_wen"}, {bus.reg_wen_o, bus.csr_wen_o, bus.illegal_o}, 3'b000);
        chk({tag, "_waddr"}, {bus.reg_waddr_o, bus.csr_waddr_o}, 17'h0);
        chk({tag, "_csr_rdata"}, bus.csr_rdata_o, 32'h0);
    endtask

    logic [6:0] opcs [12] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F,
                              7'h67, 7'h37, 7'h17, 7'h73, 7'h0F, 7'h7F};

    initial begin
        logic [31:0] ins;
        for (int k = 0; k < 32; k++) regs[k] = $urandom;
        regs[0] = 32'h0; regs[1] = 32'd10; regs[2] = 32'd20;
        csr_data = 32'h0;
        m_valid  = 1'b0;
        m_cnt    = 0;
        m_b      = '0;
        drive(0, 32'h0, 32'h0, 1, 0, 0, 5'd0);

        // Reset state
        @(posedge clk); #1;
        chk_zero_bundle("reset");
        rst = 1'b0;

        // T1: addi x5,x1,-1
        drive(1, 32'hFFF08293, 32'h100, 1, 0, 0, 5'd0);
        cycle();
        drive(0, 32'h0, 32'h0, 1, 0, 0, 5'd0);
        chk("T1_valid", bus.out_valid_o, 1'b1);
        chk("T1_op1", bus.op1_o, 32'd10);
        chk("T1_op2", bus.op2_o, 32'hFFFF_FFFF);
        chk("T1_waddr", bus.reg_waddr_o, 5'd5);
        chk("T1_wen", bus.reg_wen_o, 1'b1);
        cycle();

        // T2: back-pressure holds the bundle, then the waiting instruction goes through
        drive(1, 32'h002081B3, 32'h104, 1, 0, 0, 5'd0);
        cycle();
        drive(1, 32'h00510113, 32'h108, 0, 0, 0, 5'd0);
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("T2_in_ready", bus.in_ready_o, 1'b0);
            chk("T2_held_inst", bus.inst_o, 32'h002081B3);
        end
        bus.out_ready_i = 1'b1;
        cycle();
        chk("T2_next_inst", bus.inst_o, 32'h00510113);

        // T3: load-use on x1 while the held bundle is consumed -> bubble
        drive(1, 32'h002081B3, 32'h10C, 1, 0, 1, 5'd1);
        #1 chk("T3_in_ready", bus.in_ready_o, 1'b0);
        cycle();
        chk("T3_bubble", bus.out_valid_o, 1'b0);
        chk("T3_stall", bus.stall_cnt_o, 16'd1);
        bus.ex_load_pending_i = 1'b0;
        cycle();
        chk("T3_captured", bus.inst_o, 32'h002081B3);
        chk("T3_op2", bus.op2_o, 32'd20);

        // T4 / T4b: branch offset, illegal opcode
        drive(1, 32'hFE208CE3, 32'h110, 1, 0, 0, 5'd0);
        cycle();
        chk("T4_offset", bus.offset_o, 32'hFFFF_FFF8);
        chk("T4_wen", bus.reg_wen_o, 1'b0);
        drive(1, 32'h0000007F, 32'h114, 1, 0, 0, 5'd0);
        cycle();
        chk("T4b_illegal", bus.illegal_o, 1'b1);

        // T5: csrrs x5,mstatus,x0 is a pure read
        csr_data = 32'h1888;
        drive(1, 32'h300022F3, 32'h118, 1, 0, 0, 5'd0);
        #1 chk("T5_csr_raddr", bus.csr_raddr_o, 12'h300);
        cycle();
        chk("T5_csr_wen", bus.csr_wen_o, 1'b0);
        chk("T5_reg_wen", bus.reg_wen_o, 1'b1);
        chk("T5_waddr", bus.reg_waddr_o, 5'd5);
        chk("T5_csr_rdata", bus.csr_rdata_o, 32'h1888);

        // T6: flush while full with a valid incoming instruction
        drive(1, 32'hFFF08293, 32'h11C, 0, 1, 0, 5'd0);
        cycle();
        chk("T6_valid", bus.out_valid_o, 1'b0);
        chk("T6_not_captured", bus.inst_o, 32'h300022F3);

        // T6b: asynchronous reset in the middle of a stall
        drive(1, 32'hFFF08293, 32'h120, 1, 0, 0, 5'd0);
        cycle();
        drive(1, 32'h002081B3, 32'h124, 0, 0, 1, 5'd2);
        cycle();
        cycle();
        #3 rst = 1'b1;
        #1 chk_zero_bundle("T6b_async");
        m_valid = 1'b0; m_cnt = 0;
        bus.ex_load_pending_i = 1'b0;
        bus.out_ready_i       = 1'b1;
        @(posedge clk); #1;
        chk_zero_bundle("T6b_held");
        rst = 1'b0;

        // Randomized traffic
        for (int n = 0; n < 500; n++) begin
            ins        = $urandom;
            ins[6:0]   = opcs[$urandom_range(0, 11)];
            ins[19:15] = 5'($urandom_range(0, 3));
            ins[24:20] = 5'($urandom_range(0, 3));
            csr_data   = $urandom;
            drive($urandom_range(0, 3) != 0, ins, {$urandom_range(0, 65535), 2'b00},
                  $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 9) < 3, 5'($urandom_range(0, 3)));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
